// File: rtl/clock_gate_ctrl.sv
// Idle-detect / wake controller driving the clock-gating cell enable; outputs are state decodes.
// Sleeps after IDLE_CYCLES idle edges; wake_ack pulses WAKE_CYCLES edges after a wake source is seen.
module clock_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        activity,
  input  logic        wake_req,
  input  logic        force_on,
  output logic        gate_enable,
  output logic        asleep,
  output logic        wake_ack,
  output logic [15:0] sleep_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    WAKE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             ack_nxt;
  logic             enter_sleep;
  logic             busy;

  assign busy = activity | wake_req | force_on;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ack_nxt     = 1'b0;
    enter_sleep = 1'b0;
    case (state)
      RUN: begin
        if (busy) begin
          cnt_nxt = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nxt   = SLEEP;
          cnt_nxt     = '0;
          enter_sleep = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      SLEEP: begin
        if (busy) begin
          state_nxt = WAKE;
          cnt_nxt   = '0;
        end
      end
      WAKE: begin
        // Inputs are ignored here: the enable pipeline must refill regardless.
        if (cnt == WAKE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          ack_nxt   = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      wake_ack    <= 1'b0;
      sleep_count <= 16'd0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      wake_ack <= ack_nxt;
      if (enter_sleep && (sleep_count != 16'hFFFF)) begin
        sleep_count <= sleep_count + 16'd1;
      end
    end
  end

  assign gate_enable = (state != SLEEP);
  assign asleep      = (state == SLEEP);

endmodule

// File: tb/tb_clock_gate_ctrl.sv
// Directed bench for clock_gate_ctrl: main instance IDLE=4/WAKE=2, second instance IDLE=1/WAKE=1.
module tb_clock_gate_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        activity = 1'b1;
  logic        wake_req = 1'b0;
  logic        force_on = 1'b0;
  logic        ge, sl, ack;
  logic [15:0] sc;
  logic        ge1, sl1, ack1;
  logic [15:0] sc1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clock_gate_ctrl #(.IDLE_CYCLES(4), .WAKE_CYCLES(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .activity(activity), .wake_req(wake_req), .force_on(force_on),
    .gate_enable(ge), .asleep(sl), .wake_ack(ack), .sleep_count(sc)
  );

  clock_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(1), .CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .activity(activity), .wake_req(wake_req), .force_on(force_on),
    .gate_enable(ge1), .asleep(sl1), .wake_ack(ack1), .sleep_count(sc1)
  );

  // One rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: from SLEEP, pulse wake_req and advance to the wake_ack cycle.
  task automatic do_wake();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      activity = 1'($urandom_range(1));
      wake_req = 1'($urandom_range(1));
      force_on = 1'($urandom_range(1));
      step();
    end
    reset = 1'b0; activity = 1'b1; wake_req = 1'b0; force_on = 1'b0;
    n_checks++;
    if (ge !== 1'b1 || sl !== 1'b0 || ack !== 1'b0 || sc !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_values: ge=%b asleep=%b ack=%b count=%h, want 1 0 0 0000", ge, sl, ack, sc);
    end
    step();
    n_checks++;
    if (ge !== 1'b1 || sl !== 1'b0 || ack !== 1'b0 || sc !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_release: ge=%b asleep=%b ack=%b count=%h, want 1 0 0 0000", ge, sl, ack, sc);
    end
  endtask

  task automatic test_idle_entry();
    activity = 1'b0;
    repeat (3) step();
    n_checks++;
    if (ge !== 1'b1 || sl !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_edge3: ge=%b asleep=%b, want 1 0", ge, sl);
    end
    step();
    n_checks++;
    if (ge !== 1'b0 || sl !== 1'b1 || sc !== 16'd1) begin
      n_fail++;
      $display("FAIL idle_edge4: ge=%b asleep=%b count=%h, want 0 1 0001", ge, sl, sc);
    end
  endtask

  task automatic test_wake();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    n_checks++;
    if (ge !== 1'b1 || sl !== 1'b0 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_k: ge=%b asleep=%b ack=%b, want 1 0 0", ge, sl, ack);
    end
    step();
    n_checks++;
    if (ge !== 1'b1 || ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_k1: ge=%b ack=%b, want 1 0", ge, ack);
    end
    step();
    n_checks++;
    if (ack !== 1'b1 || ge !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_k2_ack: ack=%b ge=%b, want 1 1", ack, ge);
    end
    // Stay idle: counting must restart from zero after the wake.
    step();
    n_checks++;
    if (ack !== 1'b0) begin
      n_fail++;
      $display("FAIL wake_k3_ack_fall: ack=%b, want 0", ack);
    end
    repeat (2) step();
    n_checks++;
    if (ge !== 1'b1) begin
      n_fail++;
      $display("FAIL wake_restart_idle: ge=%b, want 1", ge);
    end
    step();
    n_checks++;
    if (ge !== 1'b0 || sc !== 16'd2) begin
      n_fail++;
      $display("FAIL wake_resleep: ge=%b count=%h, want 0 0002", ge, sc);
    end
    do_wake();
    activity = 1'b1;
    step();
  endtask

  task automatic test_activity_pulse();
    activity = 1'b0;
    repeat (2) step();
    activity = 1'b1;
    step();
    activity = 1'b0;
    repeat (3) step();
    n_checks++;
    if (ge !== 1'b1) begin
      n_fail++;
      $display("FAIL pulse_edge6: ge=%b, want 1", ge);
    end
    step();
    n_checks++;
    if (ge !== 1'b0 || sc !== 16'd3) begin
      n_fail++;
      $display("FAIL pulse_edge7: ge=%b count=%h, want 0 0003", ge, sc);
    end
    do_wake();
    activity = 1'b1;
    step();
  endtask

  task automatic test_simultaneous();
    activity = 1'b0;
    repeat (3) step();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    n_checks++;
    if (ge !== 1'b1 || sl !== 1'b0 || sc !== 16'd3) begin
      n_fail++;
      $display("FAIL simul_no_sleep: ge=%b asleep=%b count=%h, want 1 0 0003", ge, sl, sc);
    end
    repeat (3) step();
    n_checks++;
    if (ge !== 1'b1) begin
      n_fail++;
      $display("FAIL simul_cnt_cleared: ge=%b, want 1", ge);
    end
    step();
    n_checks++;
    if (ge !== 1'b0 || sc !== 16'd4) begin
      n_fail++;
      $display("FAIL simul_later_sleep: ge=%b count=%h, want 0 0004", ge, sc);
    end
    do_wake();
    activity = 1'b1;
    step();
  endtask

  task automatic test_busy_on_ack();
    activity = 1'b0;
    repeat (4) step();
    wake_req = 1'b1;
    repeat (3) step();
    n_checks++;
    if (ack !== 1'b1 || ge !== 1'b1 || sc !== 16'd5) begin
      n_fail++;
      $display("FAIL busyack_ack: ack=%b ge=%b count=%h, want 1 1 0005", ack, ge, sc);
    end
    step();
    n_checks++;
    if (ack !== 1'b0 || ge !== 1'b1) begin
      n_fail++;
      $display("FAIL busyack_hold: ack=%b ge=%b, want 0 1", ack, ge);
    end
    wake_req = 1'b0;
    repeat (3) step();
    n_checks++;
    if (ge !== 1'b1) begin
      n_fail++;
      $display("FAIL busyack_idle3: ge=%b, want 1", ge);
    end
    step();
    n_checks++;
    if (ge !== 1'b0 || sc !== 16'd6) begin
      n_fail++;
      $display("FAIL busyack_sleep: ge=%b count=%h, want 0 0006", ge, sc);
    end
    do_wake();
    activity = 1'b1;
    step();
  endtask

  task automatic test_force_on();
    activity = 1'b0;
    force_on = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      n_checks++;
      if (ge !== 1'b1 || sl !== 1'b0) begin
        n_fail++;
        $display("FAIL force_hold[%0d]: ge=%b asleep=%b, want 1 0", i, ge, sl);
      end
    end
    n_checks++;
    if (sc !== 16'd6) begin
      n_fail++;
      $display("FAIL force_count: count=%h, want 0006", sc);
    end
    force_on = 1'b0;
    repeat (4) step();
    force_on = 1'b1;
    step();
    n_checks++;
    if (ge !== 1'b1 || sc !== 16'd7) begin
      n_fail++;
      $display("FAIL force_wakes: ge=%b count=%h, want 1 0007", ge, sc);
    end
    repeat (2) step();
    n_checks++;
    if (ack !== 1'b1) begin
      n_fail++;
      $display("FAIL force_ack: ack=%b, want 1", ack);
    end
    force_on = 1'b0;
    activity = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_wake();
    activity = 1'b0;
    repeat (4) step();
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    activity = 1'b1;
    n_checks++;
    if (ge !== 1'b1 || sl !== 1'b0 || ack !== 1'b0 || sc !== 16'd0) begin
      n_fail++;
      $display("FAIL rstwake_state: ge=%b asleep=%b ack=%b count=%h, want 1 0 0 0000", ge, sl, ack, sc);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (ack !== 1'b0 || ge !== 1'b1) begin
        n_fail++;
        $display("FAIL rstwake_no_ack[%0d]: ack=%b ge=%b, want 0 1", i, ack, ge);
      end
    end
  endtask

  task automatic test_saturation();
    activity = 1'b1;
    force dut.sleep_count = 16'hFFFE;
    step();
    release dut.sleep_count;
    step();
    n_checks++;
    if (sc !== 16'hFFFE) begin
      n_fail++;
      $display("FAIL sat_preload: count=%h, want fffe", sc);
    end
    activity = 1'b0;
    repeat (4) step();
    n_checks++;
    if (sc !== 16'hFFFF || sl !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_reach: count=%h asleep=%b, want ffff 1", sc, sl);
    end
    do_wake();
    activity = 1'b0;
    repeat (4) step();
    n_checks++;
    if (sc !== 16'hFFFF || sl !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_hold: count=%h asleep=%b, want ffff 1", sc, sl);
    end
    do_wake();
    activity = 1'b1;
    step();
  endtask

  task automatic test_idle_one();
    reset = 1'b1;
    step();
    reset = 1'b0;
    activity = 1'b1;
    step();
    activity = 1'b0;
    step();
    n_checks++;
    if (ge1 !== 1'b0 || sl1 !== 1'b1 || sc1 !== 16'd1 || ge !== 1'b1) begin
      n_fail++;
      $display("FAIL idle1_sleep: ge1=%b asleep1=%b count1=%h ge=%b, want 0 1 0001 1", ge1, sl1, sc1, ge);
    end
    wake_req = 1'b1;
    step();
    wake_req = 1'b0;
    n_checks++;
    if (ge1 !== 1'b1 || ack1 !== 1'b0) begin
      n_fail++;
      $display("FAIL idle1_wake: ge1=%b ack1=%b, want 1 0", ge1, ack1);
    end
    step();
    n_checks++;
    if (ack1 !== 1'b1 || ge1 !== 1'b1) begin
      n_fail++;
      $display("FAIL idle1_ack: ack1=%b ge1=%b, want 1 1", ack1, ge1);
    end
    step();
    n_checks++;
    if (ack1 !== 1'b0 || sl1 !== 1'b1 || sc1 !== 16'd2) begin
      n_fail++;
      $display("FAIL idle1_resleep: ack1=%b asleep1=%b count1=%h, want 0 1 0002", ack1, sl1, sc1);
    end
    activity = 1'b1;
    step();
  endtask

  initial begin
    test_reset();
    test_idle_entry();
    test_wake();
    test_activity_pulse();
    test_simultaneous();
    test_busy_on_ack();
    test_force_on();
    test_reset_mid_wake();
    test_saturation();
    test_idle_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
